// File: rtl/pio_button_poller.sv
// Avalon-MM poller for a button PIO slave: periodic reads, debounce, and
// edge events presented through a one-deep valid/ready slot with irq.
module pio_button_poller #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned POLL_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic [31:0]      avm_readdata,
  output logic [WIDTH-1:0] debounced,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_rise,
  output logic [WIDTH-1:0] evt_fall,
  output logic             irq,
  output logic             overflow,
  input  logic             ovf_clear
);

  localparam int unsigned TW = $clog2(POLL_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [TW-1:0] TMAX = TW'(POLL_DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_SAMPLE,
    S_EVAL
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [TW-1:0]    r_timer;
  logic             r_read;
  logic [WIDTH-1:0] r_sample;
  logic [WIDTH-1:0] r_last;
  logic [CW-1:0]    r_stable_cnt;
  logic [WIDTH-1:0] r_debounced;
  logic             r_evt_valid;
  logic [WIDTH-1:0] r_evt_rise;
  logic [WIDTH-1:0] r_evt_fall;
  logic             r_overflow;

  logic             w_tick;
  logic             w_read_nxt;
  logic             w_capture;
  logic             w_eval;
  logic [CW-1:0]    w_cnt_sat;
  logic [CW-1:0]    w_cnt_next;
  logic             w_new_evt;
  logic             w_merge;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic             w_unused_hi;

  assign w_unused_hi = ^avm_readdata[31:WIDTH];

  assign avm_address = 2'b00;
  assign avm_read    = r_read;
  assign debounced   = r_debounced;
  assign evt_valid   = r_evt_valid;
  assign evt_rise    = r_evt_rise;
  assign evt_fall    = r_evt_fall;
  assign irq         = r_evt_valid;
  assign overflow    = r_overflow;

  // Free-running poll timer; wraps every POLL_DIV cycles
  assign w_tick = (r_timer == TMAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_read  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_read  <= w_read_nxt;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_read_nxt = 1'b0;
    w_capture  = 1'b0;
    w_eval     = 1'b0;
    case (r_state)
      S_IDLE:   if (w_tick) w_next = S_ADDR;
      S_ADDR:   w_next = S_SAMPLE;
      S_SAMPLE: begin
        w_capture = 1'b1;
        w_next    = S_EVAL;
      end
      S_EVAL: begin
        w_eval = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
    w_read_nxt = (w_next == S_ADDR);
  end

  // Debounce: the post-update count decides whether the sample is accepted
  assign w_cnt_sat  = (r_stable_cnt >= CMAX) ? CMAX : r_stable_cnt + CW'(1);
  assign w_cnt_next = (r_sample == r_last) ? w_cnt_sat : CW'(1);
  assign w_new_evt  = w_eval && (w_cnt_next >= CMAX) && (r_sample != r_debounced);
  assign w_merge    = w_new_evt && r_evt_valid && !evt_ready;
  assign w_rise     = r_sample & ~r_debounced;
  assign w_fall     = ~r_sample & r_debounced;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample     <= '0;
      r_last       <= '0;
      r_stable_cnt <= '0;
      r_debounced  <= '0;
    end else begin
      if (w_capture) r_sample <= avm_readdata[WIDTH-1:0];
      if (w_eval) begin
        r_last       <= r_sample;
        r_stable_cnt <= w_cnt_next;
      end
      if (w_new_evt) r_debounced <= r_sample;
    end
  end

  // One-deep event slot; an unaccepted event absorbs new edges by OR-merge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_evt_valid <= 1'b0;
      r_evt_rise  <= '0;
      r_evt_fall  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_merge) begin
        r_evt_rise <= r_evt_rise | w_rise;
        r_evt_fall <= r_evt_fall | w_fall;
      end else if (w_new_evt) begin
        r_evt_rise  <= w_rise;
        r_evt_fall  <= w_fall;
        r_evt_valid <= 1'b1;
      end else if (r_evt_valid && evt_ready) begin
        r_evt_valid <= 1'b0;
      end
      if (w_merge) begin
        r_overflow <= 1'b1;
      end else if (ovf_clear) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pio_button_poller.sv
// Directed bench for pio_button_poller with a registered PIO slave model and
// an expected-event scoreboard.
module tb_pio_button_poller;

  typedef struct packed {
    logic [3:0] rise;
    logic [3:0] fall;
  } evt_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = 32'h0;
  logic [3:0]  debounced;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [3:0]  evt_rise;
  logic [3:0]  evt_fall;
  logic        irq;
  logic        overflow;
  logic        ovf_clear = 1'b0;
  logic [3:0]  in_port = 4'h0;

  evt_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_read = 0;

  pio_button_poller #(
    .WIDTH(4),
    .POLL_DIV(8),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_readdata(avm_readdata),
    .debounced(debounced),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_rise(evt_rise),
    .evt_fall(evt_fall),
    .irq(irq),
    .overflow(overflow),
    .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered slave: data appears the cycle after the read strobe; junk upper bits
  always @(posedge clk) begin
    if (avm_read) avm_readdata <= ($urandom() & 32'hFFFF_FFF0) | {28'h0, in_port};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_read();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (avm_read === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("read_seen", 32'(seen), 32'd1);
    t_read = cyc;
  endtask

  task automatic sb_compare();
    evt_t e;
    chk("evt_valid_pending", 32'(evt_valid), 32'd1);
    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("evt_rise", 32'(evt_rise), 32'(e.rise));
      chk("evt_fall", 32'(evt_fall), 32'(e.fall));
    end
  endtask

  task automatic consume();
    sb_compare();
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    chk("evt_valid_drop", 32'(evt_valid), 32'd0);
  endtask

  // One full poll; optionally assert evt_ready during the EVAL cycle
  task automatic poll(input logic [3:0] val, input bit rdy_eval);
    in_port = val;
    wait_read();
    chk("avm_address", 32'(avm_address), 32'd0);
    @(negedge clk);
    chk("read_one_cycle", 32'(avm_read), 32'd0);
    @(negedge clk);
    if (rdy_eval) begin
      sb_compare();
      evt_ready = 1'b1;
    end
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_read"}, 32'(avm_read), 32'd0);
    chk({tag, "_addr"}, 32'(avm_address), 32'd0);
    chk({tag, "_deb"}, 32'(debounced), 32'd0);
    chk({tag, "_valid"}, 32'(evt_valid), 32'd0);
    chk({tag, "_rise"}, 32'(evt_rise), 32'd0);
    chk({tag, "_fall"}, 32'(evt_fall), 32'd0);
    chk({tag, "_irq"}, 32'(irq), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int   c0;
    int   prev;
    evt_t e;

    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Idle polling with buttons released
    reset_n = 1'b1;
    c0 = cyc;
    poll(4'h0, 1'b0);
    chk("first_read_latency", 32'(t_read - c0), 32'd8);
    for (int i = 0; i < 3; i++) begin
      prev = t_read;
      poll(4'h0, 1'b0);
      chk("poll_period", 32'(t_read - prev), 32'd8);
    end
    chk("idle_deb", 32'(debounced), 32'h0);
    chk("idle_valid", 32'(evt_valid), 32'd0);

    // Press 4'h5: accepted on the third matching poll
    exp_q.push_back('{rise: 4'h5, fall: 4'h0});
    poll(4'h5, 1'b0);
    poll(4'h5, 1'b0);
    chk("press_early_valid", 32'(evt_valid), 32'd0);
    chk("press_early_deb", 32'(debounced), 32'h0);
    poll(4'h5, 1'b0);
    chk("press_deb", 32'(debounced), 32'h5);
    chk("press_irq", 32'(irq), 32'd1);
    chk("press_ovf", 32'(overflow), 32'd0);
    consume();

    // Glitching input never settles
    for (int i = 0; i < 10; i++) begin
      poll((i % 2 == 0) ? 4'h1 : 4'h0, 1'b0);
      chk("glitch_valid", 32'(evt_valid), 32'd0);
      chk("glitch_deb", 32'(debounced), 32'h5);
    end

    // Last glitch sample was 0; two more zeros complete the release
    exp_q.push_back('{rise: 4'h0, fall: 4'h5});
    poll(4'h0, 1'b0);
    poll(4'h0, 1'b0);
    chk("release_deb", 32'(debounced), 32'h0);
    consume();

    // Two events without acceptance merge and set overflow
    exp_q.push_back('{rise: 4'h3, fall: 4'h0});
    repeat (3) poll(4'h3, 1'b0);
    chk("ovf_first_valid", 32'(evt_valid), 32'd1);
    chk("ovf_first_ovf", 32'(overflow), 32'd0);
    e = exp_q.pop_back();
    e.rise = e.rise | (4'h2 & ~4'h3);
    e.fall = e.fall | (~4'h2 & 4'h3);
    exp_q.push_back(e);
    repeat (3) poll(4'h2, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_deb", 32'(debounced), 32'h2);
    ovf_clear = 1'b1;
    @(negedge clk);
    ovf_clear = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    consume();

    // New event lands in the same cycle the old one is accepted
    exp_q.push_back('{rise: 4'h0, fall: 4'h2});
    repeat (3) poll(4'h0, 1'b0);
    exp_q.push_back('{rise: 4'h4, fall: 4'h0});
    poll(4'h4, 1'b0);
    poll(4'h4, 1'b0);
    poll(4'h4, 1'b1);
    chk("back2back_valid", 32'(evt_valid), 32'd1);
    chk("back2back_ovf", 32'(overflow), 32'd0);
    chk("back2back_deb", 32'(debounced), 32'h4);
    sb_compare();

    // Reset asserted during SAMPLE clears everything at once
    in_port = 4'h9;
    wait_read();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    c0 = cyc;
    poll(4'h0, 1'b0);
    chk("rst_read_latency", 32'(t_read - c0), 32'd8);
    chk("rst_deb", 32'(debounced), 32'h0);
    chk("rst_valid", 32'(evt_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
